// File: rtl/ripple_carry.sv
// ripple_carry: registered WIDTH-bit adder built from a chain of one-bit
// full adders, with a one-cycle latency and a valid flag.
// The output register holds its value when no new operands arrive.
// Optional feature: define RIPPLE_CARRY_OVERFLOW_EN to add Overflow_o, the
// registered two's-complement signed overflow (c[WIDTH] ^ c[WIDTH-1]).
module ripple_carry #(
    parameter int WIDTH = 32
) (
    input  logic             Clk_i,
    input  logic             Reset_n_i,
    input  logic [WIDTH-1:0] Number1_i,
    input  logic [WIDTH-1:0] Number2_i,
    input  logic             Carry_i,
    input  logic             Valid_i,
    output logic [WIDTH-1:0] Result_o,
    output logic             Carry_o,
    output logic             Valid_o
`ifdef RIPPLE_CARRY_OVERFLOW_EN
    ,
    output logic             Overflow_o
`endif
);

    // One-bit full adder, returned as {cout, s}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s;
        logic cout;
        s        = a ^ b ^ c;
        cout     = (a & b) | (c & (a ^ b));
        full_add = {cout, s};
    endfunction

    logic [WIDTH-1:0] sum;
    logic             carry_out;     // c[WIDTH]
    logic             carry_msb_in;  // c[WIDTH-1], carry into the MSB stage

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d,  carry_q;
    logic             valid_d,  valid_q;
`ifdef RIPPLE_CARRY_OVERFLOW_EN
    logic             overflow_d, overflow_q;
`endif

    // Ripple the carry through WIDTH full-adder stages, LSB to MSB.
    always_comb begin : ripple_chain
        logic       carry;
        logic [1:0] fa;
        // NOTE: every variable written here gets a value before any branch or loop,
        // so no path leaves it unassigned and no latch is inferred.
        carry        = Carry_i;
        fa           = 2'b00;
        sum          = '0;
        carry_msb_in = Carry_i;
        for (int i = 0; i < WIDTH; i++) begin
            // NOTE: blocking assignments are intended here: each stage must see the
            // carry produced by the stage below it within the same evaluation.
            carry_msb_in = carry;
            fa           = full_add(Number1_i[i], Number2_i[i], carry);
            sum[i]       = fa[0];
            carry        = fa[1];
        end
        carry_out = carry;
    end

    // Load a new sum on valid operands, otherwise hold the previous result.
    always_comb begin : next_state
        result_d = result_q;
        carry_d  = carry_q;
        valid_d  = Valid_i;
`ifdef RIPPLE_CARRY_OVERFLOW_EN
        overflow_d = overflow_q;
`endif
        if (Valid_i) begin
            result_d = sum;
            carry_d  = carry_out;
`ifdef RIPPLE_CARRY_OVERFLOW_EN
            overflow_d = carry_out ^ carry_msb_in;
`endif
        end
    end

    // Output register with synchronous active-low reset taking priority over Valid_i.
    always_ff @(posedge Clk_i) begin : output_reg
        if (!Reset_n_i) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples pre-edge values regardless of statement order.
            result_q <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
`ifdef RIPPLE_CARRY_OVERFLOW_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            valid_q  <= valid_d;
`ifdef RIPPLE_CARRY_OVERFLOW_EN
            overflow_q <= overflow_d;
`endif
        end
    end

    assign Result_o = result_q;
    assign Carry_o  = carry_q;
    assign Valid_o  = valid_q;
`ifdef RIPPLE_CARRY_OVERFLOW_EN
    assign Overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_ripple_carry.sv
// tb_ripple_carry: scoreboard bench for ripple_carry (WIDTH = 32).
// Expected outputs are pushed when operands are driven and popped after the
// capturing edge. Define RIPPLE_CARRY_OVERFLOW_EN to also check Overflow_o.
module tb_ripple_carry;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             valid;
        logic             ovf;
    } exp_t;

    logic             Clk_i = 1'b0;
    logic             Reset_n_i;
    logic [WIDTH-1:0] Number1_i;
    logic [WIDTH-1:0] Number2_i;
    logic             Carry_i;
    logic             Valid_i;
    logic [WIDTH-1:0] Result_o;
    logic             Carry_o;
    logic             Valid_o;
`ifdef RIPPLE_CARRY_OVERFLOW_EN
    logic             Overflow_o;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t m_state;  // last expected register contents (for hold checks)

    ripple_carry #(.WIDTH(WIDTH)) dut (
        .Clk_i     (Clk_i),
        .Reset_n_i (Reset_n_i),
        .Number1_i (Number1_i),
        .Number2_i (Number2_i),
        .Carry_i   (Carry_i),
        .Valid_i   (Valid_i),
        .Result_o  (Result_o),
        .Carry_o   (Carry_o),
        .Valid_o   (Valid_o)
`ifdef RIPPLE_CARRY_OVERFLOW_EN
        ,
        .Overflow_o(Overflow_o)
`endif
    );

    always #5 Clk_i = ~Clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Reference addition, independent of the DUT structure.
    function automatic exp_t add_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic cin);
        exp_t       e;
        logic [WIDTH:0] full;
        full    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        e.res   = full[WIDTH-1:0];
        e.carry = full[WIDTH];
        e.valid = 1'b1;
`ifdef RIPPLE_CARRY_OVERFLOW_EN
        e.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
`else
        e.ovf   = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t g;
        g.res   = Result_o;
        g.carry = Carry_o;
        g.valid = Valid_o;
`ifdef RIPPLE_CARRY_OVERFLOW_EN
        g.ovf   = Overflow_o;
`else
        g.ovf   = 1'b0;
`endif
        return g;
    endfunction

    // Drive one cycle of stimulus at the falling edge, push its expectation,
    // and return #1 after the capturing rising edge.
    task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic v, input logic rst_n, input exp_t e);
        @(negedge Clk_i);
        Number1_i = a;
        Number2_i = b;
        Carry_i   = cin;
        Valid_i   = v;
        Reset_n_i = rst_n;
        sb_q.push_back(e);
        m_state = e;
        @(posedge Clk_i);
        #1;
    endtask

    function automatic exp_t held();
        exp_t e;
        e       = m_state;
        e.valid = 1'b0;
        return e;
    endfunction

    task automatic test_reset();
        exp_t z, g, e;
        z = '0;
        for (int i = 0; i < 2; i++) begin
            step(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1, 1'b0, z);
            g = sample(); e = sb_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset[%0d] got r=%h c=%b v=%b o=%b exp r=%h c=%b v=%b o=%b",
                         i, g.res, g.carry, g.valid, g.ovf, e.res, e.carry, e.valid, e.ovf);
            end
        end
    endtask

    task automatic test_wrap();
        exp_t g, e;
        logic [WIDTH-1:0] a_t [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [WIDTH-1:0] b_t [3] = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF};
        logic             c_t [3] = '{1'b0, 1'b1, 1'b1};
        logic [WIDTH-1:0] r_t [3] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            e = '{res: r_t[i], carry: 1'b1, valid: 1'b1, ovf: 1'b0};
`ifdef RIPPLE_CARRY_OVERFLOW_EN
            e.ovf = (i == 2) ? 1'b0 : 1'b0;  // -1+1 and -1+-1+1 are in range
`endif
            step(a_t[i], b_t[i], c_t[i], 1'b1, 1'b1, e);
            g = sample(); e = sb_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL wrap[%0d] got r=%h c=%b v=%b o=%b exp r=%h c=%b v=%b o=%b",
                         i, g.res, g.carry, g.valid, g.ovf, e.res, e.carry, e.valid, e.ovf);
            end
        end
    endtask

    task automatic test_small();
        exp_t g, e;
        logic [WIDTH-1:0] a_t [6] = '{0, 1, 0, 1, 0, 1};
        logic [WIDTH-1:0] b_t [6] = '{1, 1, 0, 0, 1, 1};
        logic             c_t [6] = '{0, 0, 1, 1, 1, 1};
        logic [WIDTH-1:0] r_t [6] = '{1, 2, 1, 2, 2, 3};
        for (int i = 0; i < 6; i++) begin
            step(a_t[i], b_t[i], c_t[i], 1'b1, 1'b1,
                 '{res: r_t[i], carry: 1'b0, valid: 1'b1, ovf: 1'b0});
            g = sample(); e = sb_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL small[%0d] got r=%h c=%b v=%b o=%b exp r=%h c=%b v=%b o=%b",
                         i, g.res, g.carry, g.valid, g.ovf, e.res, e.carry, e.valid, e.ovf);
            end
        end
    endtask

    task automatic test_hold();
        exp_t g, e;
        for (int i = 0; i < 3; i++) begin
            step($urandom, $urandom, i[0], 1'b0, 1'b1, held());
            g = sample(); e = sb_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL hold[%0d] got r=%h c=%b v=%b o=%b exp r=%h c=%b v=%b o=%b",
                         i, g.res, g.carry, g.valid, g.ovf, e.res, e.carry, e.valid, e.ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t g, e;
        logic [WIDTH-1:0] a, b;
        logic             cin, v;
        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            v   = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            step(a, b, cin, v, 1'b1, v ? add_model(a, b, cin) : held());
            g = sample(); e = sb_q.pop_front(); checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL b2b[%0d] got r=%h c=%b v=%b o=%b exp r=%h c=%b v=%b o=%b",
                         i, g.res, g.carry, g.valid, g.ovf, e.res, e.carry, e.valid, e.ovf);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t g, e;
        // Nonzero result first so the reset has something to clear.
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1,
             add_model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
        void'(sb_q.pop_front());
        step(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0, '0);
        g = sample(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL mid_reset got r=%h c=%b v=%b o=%b exp r=%h c=%b v=%b o=%b",
                     g.res, g.carry, g.valid, g.ovf, e.res, e.carry, e.valid, e.ovf);
        end
        // The discarded operation must not reappear once reset is released.
        step(32'h0000_0009, 32'h0000_0001, 1'b0, 1'b0, 1'b1, held());
        g = sample(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL post_reset_hold got r=%h c=%b v=%b o=%b exp r=%h c=%b v=%b o=%b",
                     g.res, g.carry, g.valid, g.ovf, e.res, e.carry, e.valid, e.ovf);
        end
        step(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1, 1'b1,
             '{res: 32'h0000_0031, carry: 1'b0, valid: 1'b1, ovf: 1'b0});
        g = sample(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL post_reset_op got r=%h c=%b v=%b o=%b exp r=%h c=%b v=%b o=%b",
                     g.res, g.carry, g.valid, g.ovf, e.res, e.carry, e.valid, e.ovf);
        end
    endtask

`ifdef RIPPLE_CARRY_OVERFLOW_EN
    task automatic test_overflow();
        exp_t g, e;
        step(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1,
             '{res: 32'h8000_0000, carry: 1'b0, valid: 1'b1, ovf: 1'b1});
        g = sample(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL overflow_pos got r=%h c=%b v=%b o=%b exp r=%h c=%b v=%b o=%b",
                     g.res, g.carry, g.valid, g.ovf, e.res, e.carry, e.valid, e.ovf);
        end
        // Overflow flag holds with the result while Valid_i is low.
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, held());
        g = sample(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL overflow_hold got r=%h c=%b v=%b o=%b exp r=%h c=%b v=%b o=%b",
                     g.res, g.carry, g.valid, g.ovf, e.res, e.carry, e.valid, e.ovf);
        end
        step(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1,
             '{res: 32'h0000_0000, carry: 1'b1, valid: 1'b1, ovf: 1'b1});
        g = sample(); e = sb_q.pop_front(); checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL overflow_neg got r=%h c=%b v=%b o=%b exp r=%h c=%b v=%b o=%b",
                     g.res, g.carry, g.valid, g.ovf, e.res, e.carry, e.valid, e.ovf);
        end
    endtask
`endif

    initial begin
        Reset_n_i = 1'b0;
        Valid_i   = 1'b0;
        Carry_i   = 1'b0;
        Number1_i = '0;
        Number2_i = '0;
        m_state   = '0;
        test_reset();
        test_wrap();
        test_small();
        test_hold();
        test_back_to_back();
        test_mid_reset();
`ifdef RIPPLE_CARRY_OVERFLOW_EN
        test_overflow();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
